// File: rtl/ysyx_22041207_ex_mem_if.sv
// Bundle between ID/EX, the ALU and the EX->MEM stage: op input bus, ALU result/busy,
// flush, and the MEM-facing output bus. The stage itself uses the slave view.
interface ysyx_22041207_ex_mem_if #(
    parameter int XLEN = 64
) ();
    logic            flush;

    logic            in_valid;
    logic            in_ready;
    logic            in_multi;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic            in_rf_wen;
    logic            in_mem_ren;
    logic            in_mem_wen;
    logic [1:0]      in_mem_len;
    logic [XLEN-1:0] in_store_data;

    logic [XLEN-1:0] alu_res;
    logic            alu_wait;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd;
    logic            out_rf_wen;
    logic            out_mem_ren;
    logic            out_mem_wen;
    logic [1:0]      out_mem_len;
    logic [XLEN-1:0] out_store_data;

    modport master (
        output flush, in_valid, in_multi, in_pc, in_rd, in_rf_wen, in_mem_ren, in_mem_wen,
               in_mem_len, in_store_data, alu_res, alu_wait, out_ready,
        input  in_ready, out_valid, out_pc, out_res, out_rd, out_rf_wen, out_mem_ren,
               out_mem_wen, out_mem_len, out_store_data
    );

    modport slave (
        input  flush, in_valid, in_multi, in_pc, in_rd, in_rf_wen, in_mem_ren, in_mem_wen,
               in_mem_len, in_store_data, alu_res, alu_wait, out_ready,
        output in_ready, out_valid, out_pc, out_res, out_rd, out_rf_wen, out_mem_ren,
               out_mem_wen, out_mem_len, out_store_data
    );
endinterface

// File: rtl/ysyx_22041207_ex_mem.sv
// EX->MEM stage: follows the op in execution, captures the registered ALU result on the
// right cycle and queues it with its sideband in a small FIFO drained by MEM.
module ysyx_22041207_ex_mem #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22041207_ex_mem_if.slave  bus_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_MWAIT0 = 2'd2;
    localparam logic [1:0] S_MWAIT1 = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sd;
        logic [4:0]      rd;
        logic            rf_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic [1:0]      len;
    } entry_t;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]       mwait_cyc_q, mwait_cyc_d;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  sd_q;
    logic [4:0]       rd_q;
    logic             rf_wen_q;
    logic             mem_ren_q;
    logic             mem_wen_q;
    logic [1:0]       mem_len_q;

    entry_t           mem_q [DEPTH];
    entry_t           push_ent;
    entry_t           head;

    logic             in_exec, in_mwait1, head_vld, pop, push, accept;
    logic [OCC_W-1:0] occ;

    assign in_exec   = (state_q == S_EXEC);
    assign in_mwait1 = (state_q == S_MWAIT1);
    assign head_vld  = (count_q != '0);
    assign pop       = head_vld & bus_if.out_ready;

    // Occupancy once this cycle's EXEC push and MEM pop land; a new op is taken only if a
    // slot is left for its own result, so a push can never meet a full FIFO.
    assign occ = OCC_W'(count_q) + OCC_W'(in_exec) - OCC_W'(pop);
    assign bus_if.in_ready = rst & ~bus_if.flush & ((state_q == S_IDLE) | in_exec)
                           & (occ < OCC_W'(DEPTH));
    assign accept = bus_if.in_valid & bus_if.in_ready;
    assign push   = ~bus_if.flush & (in_exec | (in_mwait1 & ~bus_if.alu_wait));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_EXEC: state_d = accept ? (bus_if.in_multi ? S_MWAIT0 : S_EXEC) : S_IDLE;
            S_MWAIT0:       if (bus_if.alu_wait) state_d = S_MWAIT1;
            S_MWAIT1:       if (!bus_if.alu_wait) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        if (bus_if.flush) state_d = S_IDLE;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        mwait_cyc_d = '0;
        if (in_mwait1) mwait_cyc_d = (mwait_cyc_q == 7'h7F) ? mwait_cyc_q : mwait_cyc_q + 7'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mwait_cyc_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mwait_cyc_q <= mwait_cyc_d;
        end
    end

    assign push_ent = '{pc: pc_q, res: bus_if.alu_res, sd: sd_q, rd: rd_q, rf_wen: rf_wen_q,
                        mem_ren: mem_ren_q, mem_wen: mem_wen_q, len: mem_len_q};

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q      <= bus_if.in_pc;
            sd_q      <= bus_if.in_store_data;
            rd_q      <= bus_if.in_rd;
            rf_wen_q  <= bus_if.in_rf_wen;
            mem_ren_q <= bus_if.in_mem_ren;
            mem_wen_q <= bus_if.in_mem_wen;
            mem_len_q <= bus_if.in_mem_len;
        end
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    // Storage is not reset, so the head is forced to zero whenever the FIFO is empty.
    assign head = head_vld ? mem_q[rd_ptr_q] : '0;

    assign bus_if.out_valid      = head_vld;
    assign bus_if.out_pc         = head.pc;
    assign bus_if.out_res        = head.res;
    assign bus_if.out_store_data = head.sd;
    assign bus_if.out_rd         = head.rd;
    assign bus_if.out_rf_wen     = head.rf_wen;
    assign bus_if.out_mem_ren    = head.mem_ren;
    assign bus_if.out_mem_wen    = head.mem_wen;
    assign bus_if.out_mem_len    = head.len;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CNT_W'(DEPTH))));
    a_mwait1_bound: assert property (@(posedge clk) disable iff (!rst)
        in_mwait1 |-> (mwait_cyc_q < 7'd100));
endmodule

// File: tb/tb_ysyx_22041207_ex_mem.sv
// Bench for the EX->MEM stage: directed scenarios plus a randomized run checked against
// a queue-based model of accepted ops and their results.
module tb_ysyx_22041207_ex_mem;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int OW    = 1 + 3 * XLEN + 5 + 3 + 2;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sd;
        logic [4:0]      rd;
        logic            rf_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic [1:0]      len;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22041207_ex_mem_if #(.XLEN(XLEN)) bus ();
    ysyx_22041207_ex_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.slave)
    );

    ent_t q[$];
    ent_t infl;
    bit   infl_v, infl_m, infl_seen;
    int   wait_cnt = 0;
    int   mul_len  = 4;
    int   passed   = 0;
    int   total    = 0;

    logic [OW-1:0] act_out;
    assign act_out = {bus.out_valid, bus.out_pc, bus.out_res, bus.out_store_data, bus.out_rd,
                      bus.out_rf_wen, bus.out_mem_ren, bus.out_mem_wen, bus.out_mem_len};

    function automatic logic [OW-1:0] exp_out();
        if (q.size() == 0) return '0;
        return {1'b1, q[0].pc, q[0].res, q[0].sd, q[0].rd, q[0].rf_wen, q[0].mem_ren,
                q[0].mem_wen, q[0].len};
    endfunction

    // Ready when not busy with a MUL and the buffered results, plus the one about to
    // arrive, minus the one leaving, leave room for another.
    function automatic bit m_ready();
        int occ;
        occ = q.size() + ((infl_v && !infl_m) ? 1 : 0)
            - ((q.size() > 0 && bus.out_ready) ? 1 : 0);
        return rst && !bus.flush && !(infl_v && infl_m) && (occ < DEPTH);
    endfunction

    function automatic void m_clear();
        q.delete();
        infl_v    = 0;
        infl_m    = 0;
        infl_seen = 0;
        wait_cnt  = 0;
    endfunction

    function automatic void m_update();
        bit   acc;
        bit   pp;
        ent_t e;
        if (!rst) begin
            m_clear();
            return;
        end
        acc = bus.in_valid && m_ready();
        pp  = (q.size() > 0) && bus.out_ready;
        if (bus.flush) begin
            q.delete();
            infl_v = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (infl_v && !infl_m) begin
                e = infl; e.res = bus.alu_res; q.push_back(e); infl_v = 0;
            end else if (infl_v && infl_m) begin
                if (!infl_seen) infl_seen = bus.alu_wait;
                else if (!bus.alu_wait) begin
                    e = infl; e.res = bus.alu_res; q.push_back(e); infl_v = 0;
                end
            end
            if (acc) begin
                infl.pc = bus.in_pc; infl.sd = bus.in_store_data; infl.rd = bus.in_rd;
                infl.rf_wen = bus.in_rf_wen; infl.mem_ren = bus.in_mem_ren;
                infl.mem_wen = bus.in_mem_wen; infl.len = bus.in_mem_len; infl.res = '0;
                infl_v = 1; infl_m = bus.in_multi; infl_seen = 0;
            end
        end
        // ALU busy-flag generator: high for mul_len cycles after a MUL is taken
        if (bus.alu_wait && wait_cnt > 0) wait_cnt--;
        if (acc && bus.in_multi) wait_cnt = mul_len;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_update();
        @(negedge clk);
        bus.alu_wait = (wait_cnt > 0);
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.in_multi = 0; bus.in_pc = '0; bus.in_rd = '0;
        bus.in_rf_wen = 0; bus.in_mem_ren = 0; bus.in_mem_wen = 0; bus.in_mem_len = '0;
        bus.in_store_data = '0; bus.alu_res = '0; bus.out_ready = 0;
    endtask

    task automatic rand_op(input bit multi);
        bus.in_valid = 1; bus.in_multi = multi;
        bus.in_pc = {$urandom, $urandom}; bus.in_rd = 5'($urandom);
        bus.in_rf_wen = 1'($urandom); bus.in_mem_ren = 1'($urandom);
        bus.in_mem_wen = 1'($urandom); bus.in_mem_len = 2'($urandom);
        bus.in_store_data = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL por_in_ready act=%b req=0", bus.in_ready); else passed++;
        total++; if (act_out !== '0) $display("FAIL por_out act=%h req=0", act_out); else passed++;
        rst = 1;
        tick();
        bus.out_ready = 0; mul_len = 30;
        rand_op(0); tick();
        rand_op(1); bus.alu_res = {$urandom, $urandom}; tick();
        bus.in_valid = 0; tick(); tick();
        #1;
        total++; if (act_out !== exp_out() || bus.out_valid !== 1'b1) $display("FAIL mwait1_head act=%h req=%h", act_out, exp_out()); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL mwait1_in_ready act=%b req=0", bus.in_ready); else passed++;
        #2 rst = 0;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready act=%b req=0", bus.in_ready); else passed++;
        total++; if (act_out !== '0) $display("FAIL rst_out act=%h req=0", act_out); else passed++;
        m_clear();
        @(negedge clk);
        bus.alu_wait = 0; rst = 1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready act=%b req=1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_out_valid act=%b req=0", bus.out_valid); else passed++;
    endtask

    task automatic test_latency();
        idle_inputs(); bus.out_ready = 1;
        rand_op(0); bus.in_pc = 64'h8000_0000; bus.in_rd = 5'd5; bus.in_rf_wen = 1;
        bus.in_mem_ren = 0; bus.in_mem_wen = 0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL lat_in_ready act=%b req=1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 0; bus.alu_res = 64'h3;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_t1_valid act=%b req=0", bus.out_valid); else passed++;
        tick();
        bus.alu_res = {$urandom, $urandom};
        #1;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL lat_t2_valid act=%b req=1", bus.out_valid); else passed++;
        total++; if (bus.out_res !== 64'h3) $display("FAIL lat_res act=%h req=3", bus.out_res); else passed++;
        total++; if (bus.out_rd !== 5'd5 || bus.out_pc !== 64'h8000_0000) $display("FAIL lat_rd_pc act=%0d/%h req=5/80000000", bus.out_rd, bus.out_pc); else passed++;
        tick();
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_t3_valid act=%b req=0", bus.out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        int pops, first, last, notready, bad;
        pops = 0; first = -1; last = -1; notready = 0; bad = 0;
        idle_inputs(); bus.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) rand_op(0); else bus.in_valid = 0;
            bus.alu_res = {$urandom, $urandom};
            #1;
            if (act_out !== exp_out()) bad++;
            if (i < 4 && bus.in_ready !== 1'b1) notready++;
            if (bus.out_valid === 1'b1) begin pops++; if (first < 0) first = i; last = i; end
            tick();
        end
        total++; if (bad != 0) $display("FAIL b2b_heads act=%0d req=0 bad cycles", bad); else passed++;
        total++; if (notready != 0) $display("FAIL b2b_in_ready act=%0d req=0 stalls", notready); else passed++;
        total++; if (pops != 4 || last - first != 3) $display("FAIL b2b_pops act=%0d over %0d req=4 over 4", pops, last - first + 1); else passed++;
    endtask

    task automatic test_backpressure();
        int acc, drained, bad;
        acc = 0; drained = 0; bad = 0;
        idle_inputs(); bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            rand_op(0); bus.alu_res = {$urandom, $urandom};
            #1;
            if (bus.in_ready === 1'b1) acc++;
            tick();
        end
        bus.in_valid = 0;
        #1;
        total++; if (acc != DEPTH) $display("FAIL bp_accepted act=%0d req=%0d", acc, DEPTH); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_full act=%b req=0", bus.in_ready); else passed++;
        total++; if (act_out !== exp_out()) $display("FAIL bp_head act=%h req=%h", act_out, exp_out()); else passed++;
        bus.out_ready = 1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_release act=%b req=1", bus.in_ready); else passed++;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (act_out !== exp_out()) bad++;
            if (bus.out_valid === 1'b1) drained++;
            tick();
        end
        total++; if (bad != 0 || drained != DEPTH) $display("FAIL bp_drain act=%0d pops %0d bad req=%0d pops 0 bad", drained, bad, DEPTH); else passed++;
    endtask

    task automatic test_mul();
        int hi, rdy, early;
        hi = 0; rdy = 0; early = 0;
        idle_inputs(); bus.out_ready = 1; mul_len = 67;
        rand_op(1);
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mul_accept act=%b req=1", bus.in_ready); else passed++;
        tick();
        while (bus.alu_wait && hi < 200) begin
            rand_op(0); bus.alu_res = {$urandom, $urandom};
            #1;
            if (bus.in_ready !== 1'b0) rdy++;
            if (bus.out_valid !== 1'b0) early++;
            hi++;
            tick();
        end
        total++; if (hi != 67) $display("FAIL mul_wait_len act=%0d req=67", hi); else passed++;
        bus.in_valid = 0; bus.alu_res = 64'h2A;
        #1;
        if (bus.in_ready !== 1'b0) rdy++;
        tick();
        bus.alu_res = {$urandom, $urandom};
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 64'h2A) $display("FAIL mul_result act=%b/%h req=1/2a", bus.out_valid, bus.out_res); else passed++;
        total++; if (act_out !== exp_out()) $display("FAIL mul_head act=%h req=%h", act_out, exp_out()); else passed++;
        tick();
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mul_single_push act=%b req=0", bus.out_valid); else passed++;
        total++; if (rdy != 0 || early != 0) $display("FAIL mul_stall act=%0d ready/%0d early req=0/0", rdy, early); else passed++;
    endtask

    task automatic test_flush();
        int leak;
        // two buffered entries, flush while MEM pops and a new op is offered
        idle_inputs();
        rand_op(0); tick();
        rand_op(0); bus.alu_res = {$urandom, $urandom}; tick();
        bus.in_valid = 0; bus.alu_res = {$urandom, $urandom}; tick();
        #1;
        total++; if (act_out !== exp_out() || bus.out_valid !== 1'b1) $display("FAIL fl_prefill act=%h req=%h", act_out, exp_out()); else passed++;
        bus.flush = 1; bus.out_ready = 1; rand_op(0);
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL fl_in_ready act=%b req=0", bus.in_ready); else passed++;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_out_valid act=%b req=0", bus.out_valid); else passed++;
        // flush in EXEC while a push and a pop coincide
        bus.out_ready = 0;
        rand_op(0); tick();
        rand_op(0); bus.alu_res = {$urandom, $urandom}; tick();
        bus.in_valid = 0; bus.flush = 1; bus.out_ready = 1; tick();
        bus.flush = 0;
        leak = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.out_valid !== 1'b0) leak++;
            tick();
        end
        total++; if (leak != 0) $display("FAIL fl_exec_leak act=%0d req=0", leak); else passed++;
        // flush abandons a MUL; its later alu_wait fall must not push
        mul_len = 10;
        rand_op(1); tick();
        bus.in_valid = 0; tick(); tick(); tick();
        bus.flush = 1; tick();
        bus.flush = 0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL fl_mul_ready act=%b req=1", bus.in_ready); else passed++;
        leak = 0;
        for (int i = 0; i < 20; i++) begin
            bus.alu_res = {$urandom, $urandom};
            #1;
            if (bus.out_valid !== 1'b0) leak++;
            tick();
        end
        total++; if (leak != 0) $display("FAIL fl_mul_leak act=%0d req=0", leak); else passed++;
    endtask

    task automatic test_random();
        int bad_rdy, bad_out;
        bad_rdy = 0; bad_out = 0;
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            mul_len = $urandom_range(1, 8);
            if ($urandom_range(0, 99) < 70) rand_op($urandom_range(0, 3) == 0);
            else bus.in_valid = 0;
            bus.out_ready = ($urandom_range(0, 99) < 65);
            bus.flush     = ($urandom_range(0, 99) < 3);
            bus.alu_res   = {$urandom, $urandom};
            #1;
            total++;
            if (bus.in_ready !== m_ready()) begin
                bad_rdy++;
                if (bad_rdy < 5) $display("FAIL rnd_in_ready cyc=%0d act=%b req=%b", i, bus.in_ready, m_ready());
            end else passed++;
            total++;
            if (act_out !== exp_out()) begin
                bad_out++;
                if (bad_out < 5) $display("FAIL rnd_head cyc=%0d act=%h req=%h", i, act_out, exp_out());
            end else passed++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.alu_wait = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_mul();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
